// File: rtl/tdm_demux4_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux4_pkg
// Shared constants and state encoding for the 4-slot TDM demultiplexer.
//   NSLOTS  : number of time slots in one frame
//   SLOT_W  : width of a slot index
//   state_t : frame receiver state (IDLE waits for sof, RECV collects slots)
// -----------------------------------------------------------------------------
package tdm_demux4_pkg;

    localparam int NSLOTS = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux4_slot_decode.sv
// -----------------------------------------------------------------------------
// slot_decode
// Combinational 2-to-4 one-hot write-enable decoder.
//   sel : slot index to enable
//   en  : global enable (accepted word this cycle); all enables low when 0
//   we  : one-hot write enable, bit i set when sel == i and en is high
// -----------------------------------------------------------------------------
module slot_decode
    import tdm_demux4_pkg::*;
(
    input  logic [SLOT_W-1:0] sel,
    input  logic              en,
    output logic [NSLOTS-1:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
// Reassembles frames of four slot words from a 4:1 time-division stream and
// presents each completed frame on four registered channel outputs.
//   clk         : clock, all state updates on the rising edge
//   rst         : asynchronous active-high reset
//   din         : slot word from the upstream mux
//   din_valid   : din carries a word this cycle
//   sof         : start of frame (marks slot 0), qualified by din_valid
//   ch_a..ch_d  : last completed frame, slots 0..3
//   frame_valid : one-cycle pulse when ch_a..ch_d update
//   slot        : index of the next expected slot (0 while idle)
//   sync_err    : one-cycle pulse when a sof interrupts a partial frame
// -----------------------------------------------------------------------------
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              sof,
    output logic [W-1:0]      ch_a,
    output logic [W-1:0]      ch_b,
    output logic [W-1:0]      ch_c,
    output logic [W-1:0]      ch_d,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              sync_err
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOTS - 1);

    state_t              state;
    state_t              next_state;
    logic [SLOT_W-1:0]   next_slot;
    logic                resync;
    logic                accept;
    logic [SLOT_W-1:0]   wr_idx;
    logic [NSLOTS-1:0]   we;
    // Slot 3 goes straight from din to ch_d, so only slots 0..2 need shadowing.
    logic [W-1:0]        shadow [NSLOTS-1];

    // A word is taken when it starts a frame or continues one in progress;
    // a sof always restarts at slot 0.
    assign accept = din_valid && ((state == RECV) || sof);
    assign wr_idx = ((state == RECV) && !sof) ? slot : '0;

    slot_decode u_slot_decode (
        .sel (wr_idx),
        .en  (accept),
        .we  (we)
    );

    always_comb begin
        next_state = state;
        next_slot  = slot;
        resync     = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid && sof) begin
                    next_state = RECV;
                    next_slot  = SLOT_W'(1);
                end
            end
            RECV: begin
                if (din_valid) begin
                    if (sof) begin
                        resync    = 1'b1;
                        next_slot = SLOT_W'(1);
                    end else if (slot == LAST_SLOT) begin
                        next_state = IDLE;
                        next_slot  = '0;
                    end else begin
                        next_slot = slot + SLOT_W'(1);
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_slot  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            ch_a        <= '0;
            ch_b        <= '0;
            ch_c        <= '0;
            ch_d        <= '0;
            for (int i = 0; i < NSLOTS - 1; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            state       <= next_state;
            slot        <= next_slot;
            sync_err    <= resync;
            // The slot-3 enable only fires on the final word of a frame.
            frame_valid <= we[NSLOTS-1];
            for (int i = 0; i < NSLOTS - 1; i++) begin
                if (we[i]) begin
                    shadow[i] <= din;
                end
            end
            if (we[NSLOTS-1]) begin
                ch_a <= shadow[0];
                ch_b <= shadow[1];
                ch_c <= shadow[2];
                ch_d <= din;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] ch_a, ch_b, ch_c, ch_d;
    logic       frame_valid;
    logic [1:0] slot;
    logic       sync_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a frame is a list of words opened by a valid sof.
    logic        m_busy = 1'b0;
    logic [7:0]  m_words [$];
    logic [31:0] exp_chs = 32'h0;
    logic        exp_fv  = 1'b0;
    logic        exp_err = 1'b0;
    logic [1:0]  exp_slot = 2'd0;

    tdm_demux4 #(.W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .ch_a        (ch_a),
        .ch_b        (ch_b),
        .ch_c        (ch_c),
        .ch_d        (ch_d),
        .frame_valid (frame_valid),
        .slot        (slot),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 1'b0;
        m_words.delete();
        exp_chs  = 32'h0;
        exp_fv   = 1'b0;
        exp_err  = 1'b0;
        exp_slot = 2'd0;
    endtask

    // Drive one clock of stimulus, advance the model, return 1 ns after the edge.
    task automatic cycle(input logic v, input logic s, input logic [7:0] d);
        din       = d;
        din_valid = v;
        sof       = s;
        @(posedge clk);
        cyc++;
        exp_fv  = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            if (s) begin
                if (m_busy) exp_err = 1'b1;
                m_words.delete();
                m_words.push_back(d);
                m_busy = 1'b1;
            end else if (m_busy) begin
                m_words.push_back(d);
                if (m_words.size() == 4) begin
                    exp_chs = {m_words[0], m_words[1], m_words[2], m_words[3]};
                    exp_fv  = 1'b1;
                    m_busy  = 1'b0;
                    m_words.delete();
                end
            end
        end
        exp_slot = m_busy ? 2'(m_words.size()) : 2'd0;
        #1;
        din_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 32'h0) begin
            bad++; $display("FAIL reset_ch: got %h want 00000000", {ch_a, ch_b, ch_c, ch_d});
        end
        total++;
        if (frame_valid !== 1'b0) begin
            bad++; $display("FAIL reset_fv: got %b want 0", frame_valid);
        end
        total++;
        if (sync_err !== 1'b0) begin
            bad++; $display("FAIL reset_err: got %b want 0", sync_err);
        end
        total++;
        if (slot !== 2'd0) begin
            bad++; $display("FAIL reset_slot: got %0d want 0", slot);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        int fv_cnt = 0;
        cycle(1, 1, 8'h11); fv_cnt += int'(frame_valid);
        total++;
        if (slot !== 2'd1) begin
            bad++; $display("FAIL basic_slot: got %0d want 1", slot);
        end
        cycle(1, 0, 8'h22); fv_cnt += int'(frame_valid);
        cycle(1, 0, 8'h33); fv_cnt += int'(frame_valid);
        cycle(1, 0, 8'h44); fv_cnt += int'(frame_valid);
        total++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 32'h11223344) begin
            bad++; $display("FAIL basic_ch: got %h want 11223344", {ch_a, ch_b, ch_c, ch_d});
        end
        total++;
        if (frame_valid !== 1'b1) begin
            bad++; $display("FAIL basic_fv_latency: got %b want 1", frame_valid);
        end
        cycle(0, 0, 8'h00); fv_cnt += int'(frame_valid);
        total++;
        if (fv_cnt != 1) begin
            bad++; $display("FAIL basic_fv_count: got %0d want 1", fv_cnt);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [1:0] slots [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        int fv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, (i == 0), words[i]);
            total++;
            if (slot !== slots[i]) begin
                bad++; $display("FAIL gaps_slot word %0d: got %0d want %0d", i, slot, slots[i]);
            end
            total++;
            if (frame_valid !== (i == 3)) begin
                bad++; $display("FAIL gaps_fv word %0d: got %b want %b", i, frame_valid, (i == 3));
            end
            fv_cnt += int'(frame_valid);
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    cycle(0, 0, 8'hEE);
                    fv_cnt += int'(frame_valid);
                    total++;
                    if (slot !== slots[i]) begin
                        bad++; $display("FAIL gaps_hold word %0d: got %0d want %0d", i, slot, slots[i]);
                    end
                end
            end
        end
        total++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 32'h11223344) begin
            bad++; $display("FAIL gaps_ch: got %h want 11223344", {ch_a, ch_b, ch_c, ch_d});
        end
        total++;
        if (fv_cnt != 1) begin
            bad++; $display("FAIL gaps_fv_count: got %0d want 1", fv_cnt);
        end
    endtask

    task automatic test_resync();
        int err_cnt = 0;
        int fv_cnt  = 0;
        cycle(1, 1, 8'hAA); err_cnt += int'(sync_err); fv_cnt += int'(frame_valid);
        cycle(1, 0, 8'hBB); err_cnt += int'(sync_err); fv_cnt += int'(frame_valid);
        cycle(1, 1, 8'h01); err_cnt += int'(sync_err); fv_cnt += int'(frame_valid);
        total++;
        if (sync_err !== 1'b1) begin
            bad++; $display("FAIL resync_err_at_sof: got %b want 1", sync_err);
        end
        total++;
        if (slot !== 2'd1) begin
            bad++; $display("FAIL resync_slot: got %0d want 1", slot);
        end
        cycle(1, 0, 8'h02); err_cnt += int'(sync_err); fv_cnt += int'(frame_valid);
        cycle(1, 0, 8'h03); err_cnt += int'(sync_err); fv_cnt += int'(frame_valid);
        cycle(1, 0, 8'h04); err_cnt += int'(sync_err); fv_cnt += int'(frame_valid);
        total++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 32'h01020304) begin
            bad++; $display("FAIL resync_ch: got %h want 01020304", {ch_a, ch_b, ch_c, ch_d});
        end
        total++;
        if (err_cnt != 1 || fv_cnt != 1) begin
            bad++; $display("FAIL resync_pulses: got err=%0d fv=%0d want err=1 fv=1", err_cnt, fv_cnt);
        end
    endtask

    task automatic test_idle_discard();
        logic [7:0] words [2] = '{8'h55, 8'h66};
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, words[i]);
            total++;
            if ({ch_a, ch_b, ch_c, ch_d, frame_valid, sync_err, slot} !== {32'h01020304, 1'b0, 1'b0, 2'd0}) begin
                bad++;
                $display("FAIL idle_discard word %0d: got ch=%h fv=%b err=%b slot=%0d want ch=01020304 fv=0 err=0 slot=0",
                         i, {ch_a, ch_b, ch_c, ch_d}, frame_valid, sync_err, slot);
            end
        end
    endtask

    task automatic test_mid_reset();
        cycle(1, 1, 8'hA0);
        cycle(1, 0, 8'hA1);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 32'h0 || slot !== 2'd0) begin
            bad++; $display("FAIL midreset_async: got ch=%h slot=%0d want ch=00000000 slot=0", {ch_a, ch_b, ch_c, ch_d}, slot);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        // No sof yet: these must not complete the aborted frame.
        cycle(1, 0, 8'hB2);
        cycle(1, 0, 8'hB3);
        total++;
        if (frame_valid !== 1'b0 || {ch_a, ch_b, ch_c, ch_d} !== 32'h0) begin
            bad++; $display("FAIL midreset_nosof: got fv=%b ch=%h want fv=0 ch=00000000", frame_valid, {ch_a, ch_b, ch_c, ch_d});
        end
        cycle(1, 1, 8'h10);
        cycle(1, 0, 8'h11);
        cycle(1, 0, 8'h12);
        cycle(1, 0, 8'h13);
        total++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 32'h10111213 || frame_valid !== 1'b1) begin
            bad++; $display("FAIL midreset_frame: got ch=%h fv=%b want ch=10111213 fv=1", {ch_a, ch_b, ch_c, ch_d}, frame_valid);
        end
    endtask

    task automatic test_back_to_back();
        int fv_cyc [$];
        int err_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) begin
                cycle(1, (i == 0), 8'(8'h20 + 8'(f * 16 + i)));
                if (frame_valid) fv_cyc.push_back(cyc);
                err_cnt += int'(sync_err);
            end
        end
        cycle(0, 0, 8'h00);
        if (frame_valid) fv_cyc.push_back(cyc);
        total++;
        if (fv_cyc.size() != 2) begin
            bad++; $display("FAIL b2b_fv_count: got %0d want 2", fv_cyc.size());
        end else begin
            total++;
            if (fv_cyc[1] - fv_cyc[0] != 4) begin
                bad++; $display("FAIL b2b_spacing: got %0d want 4", fv_cyc[1] - fv_cyc[0]);
            end
        end
        total++;
        if (err_cnt != 0) begin
            bad++; $display("FAIL b2b_err: got %0d want 0", err_cnt);
        end
        total++;
        if ({ch_a, ch_b, ch_c, ch_d} !== 32'h30313233) begin
            bad++; $display("FAIL b2b_ch: got %h want 30313233", {ch_a, ch_b, ch_c, ch_d});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom % 4) != 0, ($urandom % 6) == 0, 8'($urandom));
            total++;
            if ({ch_a, ch_b, ch_c, ch_d} !== exp_chs) begin
                bad++; $display("FAIL rand_ch cyc %0d: got %h want %h", cyc, {ch_a, ch_b, ch_c, ch_d}, exp_chs);
            end
            total++;
            if (frame_valid !== exp_fv) begin
                bad++; $display("FAIL rand_fv cyc %0d: got %b want %b", cyc, frame_valid, exp_fv);
            end
            total++;
            if (sync_err !== exp_err) begin
                bad++; $display("FAIL rand_err cyc %0d: got %b want %b", cyc, sync_err, exp_err);
            end
            total++;
            if (slot !== exp_slot) begin
                bad++; $display("FAIL rand_slot cyc %0d: got %0d want %0d", cyc, slot, exp_slot);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_resync();
        test_idle_discard();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 SHALL have parameter: W, 8, data width of each slot word.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: din  input  W  serial slot word from the 4:1 time-division mux upstream.
REQ-005 SHALL have port: din_valid  input  1  din carries a slot word this cycle.
REQ-006 SHALL have port: sof  input  1  start of frame, qualified by din_valid, marks slot 0.
REQ-007 SHALL have ports: ch_a, ch_b, ch_c, ch_d  output  W each  registered frame outputs for slots 0..3.
REQ-008 SHALL have port: frame_valid  output  1  one-cycle pulse when ch_a..ch_d update.
REQ-009 SHALL have port: slot  output  2  index of the next expected slot.
REQ-010 SHALL have port: sync_err  output  1  one-cycle pulse on frame resynchronisation.

Function
REQ-011 SHALL map slot 0->ch_a, 1->ch_b, 2->ch_c, 3->ch_d, matching mux select s=0..3.
REQ-012 SHALL implement FSM states IDLE and RECV.
REQ-013 IDLE: din_valid && sof SHALL store din as shadow slot 0, set slot=1 and go to RECV.
REQ-014 IDLE: din_valid && !sof SHALL discard din with no output change and no error.
REQ-015 RECV: din_valid && !sof SHALL store din in shadow[slot] and increment slot.
REQ-016 RECV, slot==3 word accepted: on that same edge SHALL load ch_a..ch_c from shadow and ch_d from din, pulse frame_valid, set slot=0 and go to IDLE.
REQ-017 Latency SHALL be one cycle: ch_* and frame_valid are visible the cycle after the slot-3 word is sampled.
REQ-018 RECV, din_valid && sof SHALL pulse sync_err, discard the partial frame, store din as new slot 0, set slot=1 and stay in RECV.
REQ-019 din_valid low SHALL hold state, slot and shadow; gaps of any length are legal mid-frame.
REQ-020 sof without din_valid SHALL be ignored.
REQ-021 ch_a..ch_d SHALL hold their values between completed frames; partial or aborted frames never reach the outputs.
REQ-022 Back-to-back frames (sof on the cycle after slot 3) SHALL be accepted with no gap and no error.
REQ-023 slot SHALL never wrap past 3 and SHALL read 0 whenever the FSM is IDLE.

Reset
REQ-024 rst high SHALL immediately force IDLE, slot=0, shadow=0, ch_a..ch_d=0, frame_valid=0 and sync_err=0, independent of clk.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release requires a fresh sof.

Structure
REQ-026 A shared package SHALL hold NSLOTS=4, SLOT_W=2 and the IDLE/RECV state encoding.
REQ-027 One sub-module SHALL be used: slot_decode, a combinational 2-to-4 one-hot write-enable decoder gated by din_valid.

Verification
REQ-028 Reset, then frame sof+0x11, 0x22, 0x33, 0x44 on consecutive cycles -> next cycle ch_a..d=11/22/33/44, frame_valid pulses once.
REQ-029 Same frame with 2 idle cycles between each word -> identical outputs; frame_valid pulses only after 0x44; slot steps 1,2,3,0.
REQ-030 sof+0xAA, 0xBB, then sof+0x01, 0x02, 0x03, 0x04 -> sync_err pulses once at the second sof; outputs = 01/02/03/04; 0xAA/0xBB never appear.
REQ-031 Words 0x55, 0x66 without sof while IDLE -> no output change, no pulses, slot stays 0.
REQ-032 rst asserted after slot 1 of a frame -> outputs 0 immediately; a later complete frame 0x10..0x13 -> outputs 10/11/12/13.
REQ-033 Two back-to-back frames -> two frame_valid pulses 4 cycles apart, no sync_err.
